// File: rtl/arf_swt_obs_misr.sv
// Observation-flop MISR: compacts the Scan Write-Thru observation vector each
// accumulate cycle, holds the signature, and unloads it LSB-first over valid/ready.
module arf_swt_obs_misr #(
  parameter int                    OBS_FLOP_NUM = 6,
  parameter int                    MISR_WIDTH   = 16,
  parameter logic [MISR_WIDTH-1:0] MISR_POLY    = 16'h1021,
  parameter logic [MISR_WIDTH-1:0] MISR_SEED    = 16'h0000,
  parameter int                    CNT_W        = 16
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic [OBS_FLOP_NUM-1:0] obs_in,
  input  logic                    start,
  input  logic                    stop,
  input  logic                    unload_req,
  input  logic                    so_ready,
  output logic                    so_valid,
  output logic                    so_data,
  output logic [MISR_WIDTH-1:0]   sig,
  output logic [CNT_W-1:0]        acc_cnt,
  output logic [1:0]              state,
  output logic                    unload_done
);

  localparam int BCW = (MISR_WIDTH > 2) ? $clog2(MISR_WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCUM  = 2'd1,
    HOLD   = 2'd2,
    UNLOAD = 2'd3
  } state_t;

  state_t                cur_st, nxt_st;
  logic [MISR_WIDTH-1:0] shreg;
  logic [BCW-1:0]        bit_cnt;
  logic                  xfer;
  logic                  last_bit;

  // Galois-form step: shift left, fold the MSB back through the taps, XOR in obs.
  function automatic logic [MISR_WIDTH-1:0] misr_step(
    input logic [MISR_WIDTH-1:0]   cur,
    input logic [OBS_FLOP_NUM-1:0] obs
  );
    logic [MISR_WIDTH-1:0] fb;
    fb = cur[MISR_WIDTH-1] ? MISR_POLY : '0;
    return {cur[MISR_WIDTH-2:0], 1'b0} ^ fb ^ MISR_WIDTH'(obs);
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt);
    return (&cnt) ? cnt : cnt + 1'b1;
  endfunction

  assign xfer     = (cur_st == UNLOAD) && so_ready;
  assign last_bit = xfer && (bit_cnt == BCW'(MISR_WIDTH - 1));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) cur_st <= IDLE;
    else          cur_st <= nxt_st;
  end

  always_comb begin
    nxt_st = cur_st;
    case (cur_st)
      IDLE:    if (start) nxt_st = ACCUM;
      ACCUM:   if (start) nxt_st = ACCUM;
               else if (stop) nxt_st = HOLD;
      HOLD:    if (start) nxt_st = ACCUM;
               else if (unload_req) nxt_st = UNLOAD;
      UNLOAD:  if (last_bit) nxt_st = HOLD;
      default: nxt_st = IDLE;
    endcase
  end

  // so_ready only ever reaches state through a register, never an output directly.
  always_comb begin
    so_valid = (cur_st == UNLOAD);
    so_data  = shreg[0];
    state    = cur_st;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sig         <= MISR_SEED;
      acc_cnt     <= '0;
      shreg       <= '0;
      bit_cnt     <= '0;
      unload_done <= 1'b0;
    end else begin
      unload_done <= last_bit;
      case (cur_st)
        IDLE: begin
          if (start) begin
            sig     <= MISR_SEED;
            acc_cnt <= '0;
          end
        end
        ACCUM: begin
          if (start) begin
            sig     <= MISR_SEED;
            acc_cnt <= '0;
          end else if (!stop) begin
            sig     <= misr_step(sig, obs_in);
            acc_cnt <= sat_inc(acc_cnt);
          end
        end
        HOLD: begin
          if (start) begin
            sig     <= MISR_SEED;
            acc_cnt <= '0;
          end else if (unload_req) begin
            shreg   <= sig;
            bit_cnt <= '0;
          end
        end
        UNLOAD: begin
          if (xfer) begin
            shreg   <= shreg >> 1;
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/arf_swt_obs_misr.md
Name: arf_swt_obs_misr

Overview:
- Downstream consumer of the Scan Write-Thru observation flops of the array wrapper.
- Each accumulate cycle, compacts the registered observation-flop vector into a multiple-input signature register (MISR), so address/control observability survives long at-speed sequences.
- Holds the final signature and unloads it serially through a valid/ready handshake, for test-access logic or a scan-unload shifter.
- One instance per array port, on the same clock as the observation flops.

Parameters:
- OBS_FLOP_NUM, 6, width of obs_in; legal range 1..MISR_WIDTH.
- MISR_WIDTH, 16, signature width; minimum 2.
- MISR_POLY, 16'h1021, feedback taps (Galois form); bit i set = tap into bit i; width MISR_WIDTH.
- MISR_SEED, 16'h0000, value loaded on start; width MISR_WIDTH.
- CNT_W, 16, width of the accumulate-cycle counter.

Ports:
- clock  input  1  array port clock, rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- obs_in  input  OBS_FLOP_NUM  registered observation-flop outputs.
- start  input  1  pulse: seed the MISR and begin accumulating.
- stop  input  1  pulse: freeze the signature.
- unload_req  input  1  pulse: begin serial unload of the held signature.
- so_ready  input  1  downstream ready for a serial bit.
- so_valid  output  1  serial bit valid.
- so_data  output  1  serial signature bit, LSB first.
- sig  output  MISR_WIDTH  live MISR contents.
- acc_cnt  output  CNT_W  number of accumulate cycles since the last start; saturating.
- state  output  2  current state: 0 IDLE, 1 ACCUM, 2 HOLD, 3 UNLOAD.
- unload_done  output  1  one-cycle pulse after the last bit is transferred.

Behaviour:
- Reset: asserting reset_n low clears everything asynchronously, including mid-accumulate and mid-unload, with no partial unload completion.
  - state=IDLE; sig=MISR_SEED; acc_cnt=0; so_valid=0; so_data=0; unload_done=0; internal shift register=0; bit counter=0.
- Update in ACCUM, every cycle without start:
  - sig_next = {sig[W-2:0],1'b0} ^ (sig[W-1] ? MISR_POLY : 0) ^ zero_ext(obs_in), where W = MISR_WIDTH.
  - acc_cnt increments and saturates at 2^CNT_W-1.
- IDLE:
  - start: sig<=MISR_SEED, acc_cnt<=0, go to ACCUM. The first compaction happens on the following edge.
  - stop and unload_req: ignored.
- ACCUM:
  - start has priority over stop: re-seed, clear acc_cnt, stay in ACCUM.
  - else stop: go to HOLD with no update that cycle. The signature equals the compaction of obs_in sampled on every ACCUM edge before the stop edge.
  - else: compact.
  - unload_req: ignored.
- HOLD:
  - sig and acc_cnt are frozen.
  - start: re-seed and go to ACCUM.
  - else unload_req: copy sig into the shift register, clear the bit counter, go to UNLOAD.
  - stop: ignored.
- UNLOAD:
  - so_valid=1; so_data = shift_reg[0].
  - Transfer occurs when so_valid && so_ready: shift right by one and increment the bit counter.
  - Idle cycles while so_ready=0 hold so_data stable.
  - When the transfer of bit W-1 completes: so_valid=0 and unload_done=1 next cycle, then return to HOLD. sig is unchanged, so the signature can be unloaded again.
  - start, stop, unload_req are ignored until unload completes.
- so_valid never drops mid-unload without a transfer.
- Combinational paths: so_data and so_valid are registered or derived from state only; there is no combinational path from so_ready to any output.
- Latency: start to first compaction is 1 cycle. unload_req to so_valid is 1 cycle. Unload takes W cycles with so_ready held high.

Test Plan:
- Reset mid-UNLOAD after 5 bits -> next cycle state=0, so_valid=0, sig=16'h0000, acc_cnt=0; a subsequent unload_req is ignored (IDLE).
- start, then obs_in=6'h01 for 1 cycle, then obs_in=0 for 1 cycle, then stop -> sig=16'h0002, acc_cnt=2, state=HOLD.
- MISR_SEED=16'h8000, start, obs_in=0 for 1 cycle, stop -> sig=16'h1021 (feedback tap check).
- Signature 16'hA5C3 in HOLD, unload_req, so_ready toggling 1/0 -> so_data sequence 1,1,0,0,0,0,1,1,1,0,1,0,0,1,0,1 (LSB first), exactly 16 transfers; unload_done pulses once; state returns to HOLD; sig still 16'hA5C3.
- start and stop asserted in the same cycle in ACCUM after 10 cycles -> re-seed wins; acc_cnt=0, state stays ACCUM.
- CNT_W=4, 20 accumulate cycles -> acc_cnt saturates at 15.
